// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad types, row reset pattern and snapshot classifier
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      LOCKOUT
   } kp_state_t;

   typedef logic [3:0] key_code_t;

   typedef enum logic [1:0] {
      SNAP_NONE,
      SNAP_ONE,
      SNAP_MULTI
   } snap_kind_t;

   typedef struct packed {
      snap_kind_t kind;
      key_code_t  code;
   } snap_class_t;

   localparam logic [3:0] ROW_RESET = 4'b1110;

   // code is only meaningful when kind is SNAP_ONE
   function automatic snap_class_t classify_snapshot(input logic [15:0] snap);
      snap_class_t res;
      logic [4:0]  ones;
      ones     = '0;
      res.code = '0;
      for (int i = 15; i >= 0; i--) begin
         if (snap[i]) begin
            ones     = ones + 5'd1;
            res.code = key_code_t'(i);
         end
      end
      if (ones == 5'd0) begin
         res.kind = SNAP_NONE;
      end else if (ones == 5'd1) begin
         res.kind = SNAP_ONE;
      end else begin
         res.kind = SNAP_MULTI;
      end
      return res;
   endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// rtl/keypad_row_scanner.sv - row strobe rotation, column synchroniser and 16-key snapshot assembly
module keypad_row_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  col_i,
   output logic [3:0]  row_o,
   output logic [15:0] snapshot_o,
   output logic        scan_done_o
);

   localparam int unsigned      DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [3:0]       sync1_q;
   logic [3:0]       sync2_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       row_q, row_d;
   logic [15:0]      snap_q, snap_d;
   logic             done_q, done_d;
   logic             sample;

   // the row is held for SCAN_DIV cycles so the synchroniser settles before sampling
   assign sample = (div_q == DIV_LAST);

   always_comb begin
      div_d  = div_q + DIV_W'(1);
      idx_d  = idx_q;
      row_d  = row_q;
      snap_d = snap_q;
      done_d = 1'b0;
      if (sample) begin
         div_d                       = '0;
         snap_d[{idx_q, 2'b00} +: 4] = ~sync2_q;
         idx_d                       = idx_q + 2'd1;
         row_d                       = {row_q[2:0], row_q[3]};
         done_d                      = (idx_q == 2'd3);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 4'hF;
         sync2_q <= 4'hF;
         div_q   <= '0;
         idx_q   <= 2'd0;
         row_q   <= ROW_RESET;
         snap_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         sync1_q <= col_i;
         sync2_q <= sync1_q;
         div_q   <= div_d;
         idx_q   <= idx_d;
         row_q   <= row_d;
         snap_q  <= snap_d;
         done_q  <= done_d;
      end
   end

   assign row_o       = row_q;
   assign snapshot_o  = snap_q;
   assign scan_done_o = done_q;

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad reader: snapshot debounce, press/release FSM and key outputs
// Defining KEYPAD_REPEAT_EN adds auto-repeat pulses while a single key stays held.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 4,
   parameter int unsigned DEBOUNCE_SCANS = 3
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int unsigned REPEAT_SCANS   = 50
`endif
) (
   input  logic       Clk,
   input  logic       reset,
   output logic [3:0] row,
   input  logic [3:0] col,
   output key_code_t  key,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned       STAB_W   = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned      REP_W    = $clog2(REPEAT_SCANS + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

   logic [REP_W-1:0] rep_q, rep_d;
`endif

   logic [15:0]       snapshot;
   logic              scan_done;
   snap_class_t       snap_cls;
   logic              stable;
   logic              same_key;

   kp_state_t         state_q, state_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic [15:0]       prev_q, prev_d;
   key_code_t         key_q, key_d;
   logic              valid_q, valid_d;
   logic              held_q, held_d;

   keypad_row_scanner #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scanner (
      .clk_i       (Clk),
      .rst_i       (reset),
      .col_i       (col),
      .row_o       (row),
      .snapshot_o  (snapshot),
      .scan_done_o (scan_done)
   );

   assign snap_cls = classify_snapshot(snapshot);
   assign same_key = (snap_cls.kind == SNAP_ONE) && (snap_cls.code == key_q);

   always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      prev_d  = prev_q;
      key_d   = key_q;
      valid_d = 1'b0;
      held_d  = held_q;
      stable  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_d   = rep_q;
`endif
      if (scan_done) begin
         prev_d = snapshot;
         if (snapshot != prev_q) begin
            stab_d = STAB_W'(1);
         end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + STAB_W'(1);
         end
         // decisions use the count including this scan
         stable = (stab_d == STAB_MAX);
         case (state_q)
            IDLE: begin
               if (stable && snap_cls.kind == SNAP_ONE) begin
                  key_d   = snap_cls.code;
                  valid_d = 1'b1;
                  held_d  = 1'b1;
                  state_d = PRESSED;
`ifdef KEYPAD_REPEAT_EN
                  rep_d   = '0;
`endif
               end
            end
            PRESSED: begin
               if (!same_key && stable) begin
                  held_d  = 1'b0;
                  state_d = (snap_cls.kind == SNAP_NONE) ? IDLE : LOCKOUT;
               end
`ifdef KEYPAD_REPEAT_EN
               if (same_key) begin
                  if (rep_q == REP_LAST) begin
                     valid_d = 1'b1;
                     rep_d   = '0;
                  end else begin
                     rep_d = rep_q + REP_W'(1);
                  end
               end
`endif
            end
            LOCKOUT: begin
               if (stable && snap_cls.kind == SNAP_NONE) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         stab_q  <= '0;
         prev_q  <= '0;
         key_q   <= '0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stab_q  <= stab_d;
         prev_q  <= prev_d;
         key_q   <= key_d;
         valid_q <= valid_d;
         held_q  <= held_d;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end
`endif

   assign key       = key_q;
   assign key_valid = valid_q;
   assign key_held  = held_q;

endmodule
